bram_queue_reader: RTL and testbench

- Consumer/initiator that drives one port of a dual-port 32-bit BRAM holding a circular command queue; a producer writes entries through the other port.
- Polls the current slot. A valid entry (bit 31 set) is presented on a valid/ready output stream.
- After the handshake the block writes zero to the slot to release it, then advances the read pointer with wrap-around.

---
 rtl/bram_queue_pkg.sv | 22 ++
 rtl/bram_queue_reader.sv | 144 ++++++++++++++
 tb/tb_bram_queue_reader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_queue_pkg.sv
// ---------------------------------------------------------------------------
// bram_queue_pkg
// Shared definitions for the BRAM command-queue reader.
//   stateT     : reader FSM states
//   VALID_BIT  : slot bit that marks an occupied entry
//   SLOT_BYTES : byte stride between consecutive 32-bit slots
// ---------------------------------------------------------------------------
package bram_queue_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CHECK,
      OUTPUT,
      CLEAR,
      WAIT
   } stateT;

   localparam int          VALID_BIT  = 31;
   localparam logic [31:0] SLOT_BYTES = 32'd4;

endpackage

// File: rtl/bram_queue_reader.sv
// ---------------------------------------------------------------------------
// bram_queue_reader
// Consumer side of a circular command queue held in a dual-port 32-bit BRAM.
// The block polls the current slot, presents an occupied entry on a
// valid/ready stream, writes zero back to release the slot and then moves
// on to the next slot (wrapping at QUEUE_LEN).
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   enable           : polling permitted while high
//   mem_en/mem_we    : BRAM port enable and byte write enables
//   mem_addr/mem_din : BRAM byte address and write data
//   mem_dout         : BRAM read data, one cycle after a read enable
//   m_valid/m_ready  : output stream handshake
//   m_data           : entry payload (slot bits 30:0)
//   rd_ptr           : current slot index
//   consumed_cnt     : number of entries consumed (wraps)
// ---------------------------------------------------------------------------
module bram_queue_reader
   import bram_queue_pkg::*;
#(
   parameter int          QUEUE_LEN  = 64,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          POLL_DELAY = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   output logic                         mem_en,
   output logic [3:0]                   mem_we,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_din,
   input  logic [31:0]                  mem_dout,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [30:0]                  m_data,
   output logic [$clog2(QUEUE_LEN)-1:0] rd_ptr,
   output logic [31:0]                  consumed_cnt
);

   localparam int PW = $clog2(QUEUE_LEN);
   localparam int CW = (POLL_DELAY > 0) ? $clog2(POLL_DELAY + 1) : 1;

   stateT         state;
   logic [CW-1:0] pollCnt;

   // Byte address of a slot; plain 32-bit arithmetic so the result wraps
   // the same way the memory bus does.
   function automatic logic [31:0] slotAddr(input logic [PW-1:0] ptr);
      return BASE_ADDR + {{(32 - PW){1'b0}}, ptr} * SLOT_BYTES;
   endfunction

   // Single FSM with every output registered. mem_en/mem_we are pulsed for
   // exactly one cycle on entry to ISSUE (read) and CLEAR (zero write), so a
   // read and a write can never share a cycle. The pointer and the consumed
   // count advance on entry to CLEAR, which lets the following ISSUE use
   // rd_ptr directly for the next slot's address. Polling resumes only at the
   // IDLE, CLEAR-exit and WAIT-exit decision points, so dropping enable never
   // strands an entry half-consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pollCnt      <= '0;
         rd_ptr       <= '0;
         consumed_cnt <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 4'h0;
         mem_addr     <= '0;
         mem_din      <= '0;
         m_valid      <= 1'b0;
         m_data       <= '0;
      end else begin
         mem_en  <= 1'b0;
         mem_we  <= 4'h0;
         mem_din <= '0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state    <= ISSUE;
                  mem_en   <= 1'b1;
                  mem_addr <= slotAddr(rd_ptr);
               end
            end
            ISSUE: begin
               state <= CHECK;
            end
            CHECK: begin
               if (mem_dout[VALID_BIT]) begin
                  m_data  <= mem_dout[VALID_BIT-1:0];
                  m_valid <= 1'b1;
                  state   <= OUTPUT;
               end else if (POLL_DELAY == 0) begin
                  if (enable) begin
                     state    <= ISSUE;
                     mem_en   <= 1'b1;
                     mem_addr <= slotAddr(rd_ptr);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  pollCnt <= CW'(POLL_DELAY);
                  state   <= WAIT;
               end
            end
            OUTPUT: begin
               if (m_ready) begin
                  m_valid      <= 1'b0;
                  state        <= CLEAR;
                  mem_en       <= 1'b1;
                  mem_we       <= 4'hF;
                  mem_addr     <= slotAddr(rd_ptr);
                  rd_ptr       <= rd_ptr + 1'b1;
                  consumed_cnt <= consumed_cnt + 32'd1;
               end
            end
            CLEAR: begin
               if (enable) begin
                  state    <= ISSUE;
                  mem_en   <= 1'b1;
                  mem_addr <= slotAddr(rd_ptr);
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               pollCnt <= pollCnt - 1'b1;
               if (pollCnt <= CW'(1)) begin
                  if (enable) begin
                     state    <= ISSUE;
                     mem_en   <= 1'b1;
                     mem_addr <= slotAddr(rd_ptr);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_queue_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_queue_reader
// Drives bram_queue_reader against a dual-port memory model. A producer
// writes entries through port B and pushes the expected payload and release
// address into scoreboard queues; a monitor pops and compares whenever the
// reader presents an entry or releases a slot.
// ---------------------------------------------------------------------------
module tb_bram_queue_reader;

   localparam int          QL   = 4;
   localparam int          PD   = 4;
   localparam logic [31:0] BASE = 32'h0;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        m_valid;
   logic        m_ready;
   logic [30:0] m_data;
   logic [1:0]  rd_ptr;
   logic [31:0] consumed_cnt;

   bram_queue_reader #(
      .QUEUE_LEN (QL),
      .BASE_ADDR (BASE),
      .POLL_DELAY(PD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .rd_ptr      (rd_ptr),
      .consumed_cnt(consumed_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port memory: port A belongs to the reader (read-first), port B is
   // the producer's write-only port.
   logic [31:0] mem [QL] = '{default: 32'h0};
   logic        pbWe;
   logic [1:0]  pbIdx;
   logic [31:0] pbData;
   logic [31:0] aOff;
   assign aOff = mem_addr - BASE;

   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[aOff[3:2]][8*b +: 8] <= mem_din[8*b +: 8];
         mem_dout <= mem[aOff[3:2]];
      end
      if (pbWe) mem[pbIdx] <= pbData;
   end

   // Reference model state: queue of payloads in delivery order, queue of
   // release addresses, the slot the reader should be polling, producer state.
   int          checksTotal  = 0;
   int          checksPassed = 0;
   logic [30:0] expQ [$];
   logic [31:0] clrQ [$];
   int          refPtr       = 0;
   int          wp           = 0;
   int          producedCnt  = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Producer write of one entry into the next free slot, recorded in the
   // scoreboard. Called aligned to 1 time unit after a rising edge.
   task automatic applyStimulus(input logic [30:0] payload);
      int guard = 0;
      while (mem[wp] != 32'h0 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (mem[wp] != 32'h0) begin
         checkOutput("producer slot free", mem[wp], 32'h0);
         return;
      end
      pbIdx  = 2'(wp);
      pbData = {1'b1, payload};
      pbWe   = 1'b1;
      expQ.push_back(payload);
      clrQ.push_back(BASE + 32'(wp * 4));
      @(posedge clk); #1;
      pbWe = 1'b0;
      wp   = (wp + 1) % QL;
      producedCnt++;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n = 0;
      while ((expQ.size() != 0 || clrQ.size() != 0) && n < maxCycles) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain complete", 32'(expQ.size() + clrQ.size()), 32'h0);
   endtask

   task automatic waitValid(input int maxCycles);
      int n = 0;
      while (!m_valid && n < maxCycles) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("m_valid arrives", {31'b0, m_valid}, 32'h1);
   endtask

   task automatic resetModel();
      expQ.delete();
      clrQ.delete();
      refPtr      = 0;
      wp          = 0;
      producedCnt = 0;
   endtask

   // Monitor: every presented entry must match the scoreboard head and the
   // port must stay quiet while it is presented; every read must target the
   // model's current slot and every write must release the expected slot.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("m_valid without entry", {31'b0, m_valid}, 32'h0);
            end else begin
               checkOutput("m_data", {1'b0, m_data}, {1'b0, expQ[0]});
               checkOutput("no access while valid", {31'b0, mem_en}, 32'h0);
               if (m_ready) void'(expQ.pop_front());
            end
         end
         if (mem_en) begin
            if (mem_we == 4'h0) begin
               checkOutput("poll addr", mem_addr, BASE + 32'(refPtr * 4));
            end else begin
               checkOutput("clear we", {28'b0, mem_we}, 32'hF);
               checkOutput("clear din", mem_din, 32'h0);
               if (clrQ.size() == 0) checkOutput("clear without entry", {28'b0, mem_we}, 32'h0);
               else checkOutput("clear addr", mem_addr, clrQ.pop_front());
               refPtr = (refPtr + 1) % QL;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", checksPassed, checksTotal + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          prev;
      logic [30:0] p2;
      rst     = 1'b1;
      enable  = 1'b1;
      m_ready = 1'b0;
      pbWe    = 1'b0;
      pbIdx   = 2'd0;
      pbData  = 32'h0;
      repeat (3) @(posedge clk);
      #1;

      // Reset values.
      checkOutput("rst mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("rst mem_we", {28'b0, mem_we}, 32'h0);
      checkOutput("rst mem_addr", mem_addr, 32'h0);
      checkOutput("rst mem_din", mem_din, 32'h0);
      checkOutput("rst m_valid", {31'b0, m_valid}, 32'h0);
      checkOutput("rst m_data", {1'b0, m_data}, 32'h0);
      checkOutput("rst rd_ptr", {30'b0, rd_ptr}, 32'h0);
      checkOutput("rst consumed_cnt", consumed_cnt, 32'h0);

      // Empty queue: first read on the second cycle after release, then one
      // read every POLL_DELAY+2 cycles.
      @(posedge clk); #1;
      rst  = 1'b0;
      prev = -1;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         if (mem_en) begin
            if (prev < 0) checkOutput("first poll cycle", 32'(n), 32'd2);
            else checkOutput("poll period", 32'(n - prev), 32'(PD + 2));
            prev = n;
         end
      end
      checkOutput("polls seen", {31'b0, prev >= 0}, 32'h1);
      @(posedge clk); #1;

      // Single entry with ready held high.
      m_ready = 1'b1;
      applyStimulus(31'h5);
      waitDrain(100);
      checkOutput("consumed after one", consumed_cnt, 32'd1);
      checkOutput("rd_ptr after one", {30'b0, rd_ptr}, 32'd1);

      // Downstream stall for ten cycles.
      m_ready = 1'b0;
      applyStimulus(31'($urandom));
      waitValid(60);
      repeat (10) @(posedge clk);
      #1;
      m_ready = 1'b1;
      waitDrain(60);

      // Burst across the wrap point.
      for (int i = 1; i <= 5; i++) applyStimulus(31'(i));
      waitDrain(300);
      checkOutput("consumed after burst", consumed_cnt, 32'(producedCnt));
      checkOutput("rd_ptr after burst", {30'b0, rd_ptr}, 32'(wp));

      // Reset in the middle of presenting slot 2.
      rst = 1'b1;
      resetModel();
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(31'($urandom));
      applyStimulus(31'($urandom));
      waitDrain(100);
      m_ready = 1'b0;
      p2 = 31'($urandom);
      applyStimulus(p2);
      waitValid(60);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst m_valid", {31'b0, m_valid}, 32'h0);
      checkOutput("async rst m_data", {1'b0, m_data}, 32'h0);
      checkOutput("async rst mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("async rst rd_ptr", {30'b0, rd_ptr}, 32'h0);
      checkOutput("async rst consumed", consumed_cnt, 32'h0);
      checkOutput("slot 2 kept", mem[2], {1'b1, p2});
      resetModel();
      @(posedge clk); #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(31'($urandom));
      applyStimulus(31'($urandom));
      expQ.push_back(p2);
      clrQ.push_back(BASE + 32'd8);
      wp          = 3;
      producedCnt = 3;
      waitDrain(200);
      checkOutput("consumed after redelivery", consumed_cnt, 32'd3);
      checkOutput("rd_ptr after redelivery", {30'b0, rd_ptr}, 32'd3);

      // Drop enable while an entry is presented.
      m_ready = 1'b0;
      applyStimulus(31'($urandom));
      waitValid(60);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      m_ready = 1'b1;
      waitDrain(60);
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         checkOutput("disabled no mem_en", {31'b0, mem_en}, 32'h0);
      end
      @(posedge clk); #1;
      enable = 1'b1;
      applyStimulus(31'($urandom));
      waitDrain(100);
      checkOutput("consumed after enable", consumed_cnt, 32'(producedCnt));
      checkOutput("rd_ptr after enable", {30'b0, rd_ptr}, 32'(wp));

      // Randomised producer and downstream back-pressure.
      for (int c = 0; c < 400; c++) begin
         m_ready = 1'($urandom % 2);
         if (($urandom % 3) == 0 && mem[wp] == 32'h0) begin
            logic [30:0] pl;
            pl     = 31'($urandom);
            pbIdx  = 2'(wp);
            pbData = {1'b1, pl};
            pbWe   = 1'b1;
            expQ.push_back(pl);
            clrQ.push_back(BASE + 32'(wp * 4));
            wp = (wp + 1) % QL;
            producedCnt++;
         end else begin
            pbWe = 1'b0;
         end
         @(posedge clk); #1;
      end
      pbWe    = 1'b0;
      m_ready = 1'b1;
      waitDrain(500);
      checkOutput("final consumed", consumed_cnt, 32'(producedCnt));
      checkOutput("final rd_ptr", {30'b0, rd_ptr}, 32'(wp));

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
